// File: rtl/fb_scanout.sv
// fb_scanout: framebuffer scanout stage. Prefetches the front buffer from VRAM
// into a small FIFO, hands out one RGB565 pixel per display-enable cycle, and
// returns a one-cycle vsync pulse so buffer swaps land on frame boundaries.
//
// VRAM read handshake: vram_sel_o and vram_addr_o rise together and are held
// stable until the cycle in which vram_ack_i is high; that cycle carries
// vram_data_in_i and retires the request. At most one request is outstanding.
module fb_scanout #(
   parameter int          FB_WIDTH        = 320,
   parameter int          FB_HEIGHT       = 240,
   parameter int          FIFO_DEPTH      = 16,
   parameter logic [15:0] UNDERFLOW_COLOR = 16'h0000
) (
   input  logic        clk,
   input  logic        reset_i,
   input  logic [31:0] front_addr_i,
   input  logic        frame_start_i,
   input  logic        de_i,
   output logic [15:0] pixel_o,
   output logic        pixel_valid_o,
   output logic        underflow_o,
   output logic        vsync_o,
   output logic        vram_sel_o,
   output logic [31:0] vram_addr_o,
   input  logic        vram_ack_i,
   input  logic [15:0] vram_data_in_i
);

   localparam int TOTAL = FB_WIDTH * FB_HEIGHT;
   localparam int CNT_W = $clog2(TOTAL + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
   localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_WAIT  = 2'd2,
      S_FLUSH = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       base_q;
   logic [CNT_W-1:0]  fetch_cnt;

   logic [15:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PTR_W:0]    fifo_count;
   logic              fifo_empty;

   logic              issue;       // launch a read this cycle
   logic              req_done;    // outstanding read retires this cycle
   logic              push;        // ack data is kept
   logic              pop;         // a pixel leaves the FIFO
   logic              clear;       // new frame: empty FIFO, zero counter, clear underflow
   logic              latch_base;  // capture front_addr_i
   logic              vsync_d;

   assign fifo_empty = (fifo_count == '0);
   // A frame restart wins over a pop in the same cycle.
   assign pop = de_i && !fifo_empty && !clear;

   // Next-state and control decode; frame_start_i has priority everywhere.
   always_comb begin
      state_d    = state_q;
      issue      = 1'b0;
      req_done   = 1'b0;
      push       = 1'b0;
      clear      = 1'b0;
      latch_base = 1'b0;
      vsync_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (frame_start_i) begin
               state_d    = S_FETCH;
               clear      = 1'b1;
               latch_base = 1'b1;
               vsync_d    = 1'b1;
            end
         end
         S_FETCH: begin
            if (frame_start_i) begin
               state_d    = S_FETCH;
               clear      = 1'b1;
               latch_base = 1'b1;
               vsync_d    = 1'b1;
            end else if ((fifo_count < DEPTH_C) && (fetch_cnt < TOTAL_C)) begin
               issue   = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (frame_start_i) begin
               latch_base = 1'b1;
               vsync_d    = 1'b1;
               if (vram_ack_i) begin
                  // Request completes right now: nothing left to drain.
                  req_done = 1'b1;
                  clear    = 1'b1;
                  state_d  = S_FETCH;
               end else begin
                  state_d = S_FLUSH;
               end
            end else if (vram_ack_i) begin
               req_done = 1'b1;
               push     = 1'b1;
               state_d  = S_FETCH;
            end
         end
         S_FLUSH: begin
            // Stale data from the old frame is dropped; only the address moves.
            if (frame_start_i) begin
               latch_base = 1'b1;
            end
            if (vram_ack_i) begin
               req_done = 1'b1;
               clear    = 1'b1;
               state_d  = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, base address, fetch counter, vsync and VRAM request registers.
   always_ff @(posedge clk) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         base_q      <= '0;
         fetch_cnt   <= '0;
         vsync_o     <= 1'b0;
         vram_sel_o  <= 1'b0;
         vram_addr_o <= '0;
      end else begin
         state_q <= state_d;
         vsync_o <= vsync_d;
         if (latch_base) begin
            base_q <= front_addr_i;
         end
         if (clear) begin
            fetch_cnt <= '0;
         end else if (push) begin
            fetch_cnt <= fetch_cnt + 1'b1;
         end
         if (issue) begin
            vram_sel_o  <= 1'b1;
            vram_addr_o <= base_q + 32'(fetch_cnt);
         end else if (req_done) begin
            vram_sel_o <= 1'b0;
         end
      end
   end

   // FIFO storage; pointers alone define validity, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= vram_data_in_i;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset_i || clear) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Registered pixel output and sticky underflow flag.
   always_ff @(posedge clk) begin
      if (reset_i) begin
         pixel_o       <= '0;
         pixel_valid_o <= 1'b0;
         underflow_o   <= 1'b0;
      end else begin
         if (de_i) begin
            if (pop) begin
               pixel_o       <= fifo_mem[rd_ptr];
               pixel_valid_o <= 1'b1;
            end else begin
               pixel_o       <= UNDERFLOW_COLOR;
               pixel_valid_o <= 1'b0;
            end
         end else begin
            pixel_valid_o <= 1'b0;
         end
         if (clear) begin
            underflow_o <= 1'b0;
         end else if (de_i && fifo_empty) begin
            underflow_o <= 1'b1;
         end
      end
   end

endmodule
